// File: rtl/qnigma_add_seq.sv
// qnigma_add_seq: streaming multi-limb adder, one limb per accepted beat.
// Limbs arrive least-significant first; the carry is chained between limbs
// through a 1-bit register and the result limb is registered behind a
// valid/ready output stage.
//
// Optional feature: define QNIGMA_ADD_SEQ_SUB_EN to add the s_sub port.
// A word opened with s_sub=1 computes A-B as A + ~B + 1, and m_c then
// reports the borrow (1 when A < B).
//
// Handshake: a beat transfers on a port when its valid and ready are both
// high at a rising clk edge. Once m_val is high, the m_* payload is held
// stable until m_rdy is seen. s_rdy is combinational (!m_val || m_rdy), so
// a consume and a new accept can happen in the same cycle with no bubble.
//
// dbg_state exposes the word FSM (0 = FIRST, 1 = BODY).
module qnigma_add_seq #(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_val,
    output logic                           s_rdy,
    input  logic [W-1:0]                   s_a,
    input  logic [W-1:0]                   s_b,
    input  logic                           s_last,
`ifdef QNIGMA_ADD_SEQ_SUB_EN
    input  logic                           s_sub,
`endif
    output logic                           m_val,
    input  logic                           m_rdy,
    output logic [W-1:0]                   m_q,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_idx,
    output logic                           m_last,
    output logic                           m_c,
    output logic                           dbg_state
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_BODY  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] cnt_q;
    logic          carry_q;

    logic          acc;
    logic          fin;
    logic          sub_eff;
    logic          ci;
    logic [W-1:0]  b_eff;
    logic [W:0]    sum;

`ifdef QNIGMA_ADD_SEQ_SUB_EN
    logic          sub_q;
`endif

    assign s_rdy     = !m_val || m_rdy;
    assign dbg_state = state_q;

    // Limb datapath and next-state decode: operand conditioning, carry-in
    // selection, sum, and forced termination when the word reaches N limbs.
    always_comb begin
        acc     = s_val && s_rdy;
        fin     = s_last || (cnt_q == IW'(N - 1));
        sub_eff = 1'b0;
        b_eff   = s_b;
`ifdef QNIGMA_ADD_SEQ_SUB_EN
        sub_eff = (state_q == ST_FIRST) ? s_sub : sub_q;
        b_eff   = sub_eff ? ~s_b : s_b;
`endif
        // The first limb of a word takes the carry-init (1 for subtract),
        // later limbs take the carry stored from the previous limb.
        ci      = (state_q == ST_FIRST) ? sub_eff : carry_q;
        sum     = {1'b0, s_a} + {1'b0, b_eff} + {{W{1'b0}}, ci};
        state_d = state_q;
        if (acc) begin
            state_d = fin ? ST_FIRST : ST_BODY;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Carry chain and limb counter; both return to zero after a final limb.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (acc) begin
            carry_q <= fin ? 1'b0 : sum[W];
            cnt_q   <= fin ? '0 : cnt_q + IW'(1);
        end
    end

`ifdef QNIGMA_ADD_SEQ_SUB_EN
    // Subtract select is captured on the opening limb and held for the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (acc && (state_q == ST_FIRST)) begin
            sub_q <= s_sub;
        end
    end
`endif

    // Output register: load on accept, drop valid on a consume with no
    // accept, otherwise hold the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_val  <= 1'b0;
            m_q    <= '0;
            m_idx  <= '0;
            m_last <= 1'b0;
            m_c    <= 1'b0;
        end else if (acc) begin
            m_val  <= 1'b1;
            m_q    <= sum[W-1:0];
            m_idx  <= cnt_q;
            m_last <= fin;
            // Carry for add, inverted carry (borrow) for subtract.
            m_c    <= fin ? (sum[W] ^ sub_eff) : 1'b0;
        end else if (m_rdy) begin
            m_val  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qnigma_add_seq.sv
// tb_qnigma_add_seq: directed and randomized stimulus for qnigma_add_seq
// (W=8, N=4) against a word-level arithmetic reference model.
module tb_qnigma_add_seq;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int EW = W + IW + 2;
`ifdef QNIGMA_ADD_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_val = 1'b0;
  logic          s_rdy;
  logic [W-1:0]  s_a = '0;
  logic [W-1:0]  s_b = '0;
  logic          s_last = 1'b0;
`ifdef QNIGMA_ADD_SEQ_SUB_EN
  logic          s_sub_tb = 1'b0;
`endif
  logic          m_val;
  logic          m_rdy = 1'b0;
  logic [W-1:0]  m_q;
  logic [IW-1:0] m_idx;
  logic          m_last;
  logic          m_c;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {m_c, m_last, m_idx, m_q} in output order.
  logic [EW-1:0] exp_q[$];
  logic          hold_valid = 1'b0;
  logic [EW-1:0] hold_val = '0;

  // Reference model state: word built up as integers.
  int            mk = 0;
  logic [63:0]   ma = '0;
  logic [63:0]   mb = '0;
  logic          msub = 1'b0;

  qnigma_add_seq #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_val     (s_val),
    .s_rdy     (s_rdy),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_last    (s_last),
`ifdef QNIGMA_ADD_SEQ_SUB_EN
    .s_sub     (s_sub_tb),
`endif
    .m_val     (m_val),
    .m_rdy     (m_rdy),
    .m_q       (m_q),
    .m_idx     (m_idx),
    .m_last    (m_last),
    .m_c       (m_c),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: result limb k is limb k of (A +/- B) over the
  // limbs seen so far; carry/borrow comes from full-width comparison.
  task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic l, input logic sb);
    logic [63:0] r;
    logic        fin;
    logic [W-1:0] q;
    logic        c;
    if (mk == 0) begin
      ma   = '0;
      mb   = '0;
      msub = SUB_EN && sb;
    end
    ma  = ma | (64'(a) << (mk * W));
    mb  = mb | (64'(b) << (mk * W));
    fin = l || (mk == N - 1);
    r   = msub ? (ma - mb) : (ma + mb);
    q   = W'(r >> (mk * W));
    if (!fin) c = 1'b0;
    else if (msub) c = (ma < mb);
    else c = 1'(r >> ((mk + 1) * W));
    exp_q.push_back({c, fin, IW'(mk), q});
    mk = fin ? 0 : mk + 1;
  endtask

  // Driver: one cycle of stimulus plus scoreboard checks for that cycle.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic l, input logic sb, input logic r);
    logic [EW-1:0] got;
    @(negedge clk);
    s_val = v; s_a = a; s_b = b; s_last = l; m_rdy = r;
`ifdef QNIGMA_ADD_SEQ_SUB_EN
    s_sub_tb = sb;
`endif
    #1;
    got = {m_c, m_last, m_idx, m_q};
    check("m_val", 32'(m_val), 32'(exp_q.size() != 0));
    check("s_rdy", 32'(s_rdy), 32'((exp_q.size() == 0) || r));
    check("state", 32'(dbg_state), 32'(mk != 0));
    if (hold_valid) check("hold", 32'(got), 32'(hold_val));
    if (m_val && m_rdy && (exp_q.size() != 0)) check("out", 32'(got), 32'(exp_q.pop_front()));
    hold_valid = m_val && !m_rdy;
    hold_val   = got;
    if (v && s_rdy) model_accept(a, b, l, sb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_val = 1'b0; m_rdy = 1'b0;
    exp_q.delete();
    mk = 0;
    hold_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_s_rdy", 32'(s_rdy), 32'd1);
    rst = 1'b0;
    check("rst_m_val", 32'(m_val), 32'd0);
    check("rst_m_q", 32'(m_q), 32'd0);
    check("rst_m_idx", 32'(m_idx), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_c", 32'(m_c), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    do_reset();

    // Two-limb word with carry across limbs.
    step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    // Single limb with carry out, then a word that must start with ci=0.
    step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    drain();

    // Output stall for three cycles, then streaming resumes.
    step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h55, 8'hAA, 1'b1, 1'b0, 1'b1);
    drain();

    // Forced termination at N limbs; next limb opens a fresh word.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    drain();

    // Reset in the middle of a word.
    step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

`ifdef QNIGMA_ADD_SEQ_SUB_EN
    // Subtract words: single-limb borrow, and a two-limb borrow chain.
    step(1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    drain();
`endif

    // Randomized traffic with random back-pressure and one reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
